// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK transmit front end.
package qpsk_pkg;

  typedef struct packed {
    logic i;
    logic q;
  } dibit_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sym_state_t;

  localparam logic [1:0] QPSK_IDLE_DIBIT = 2'b11;

endpackage

// File: rtl/dibit_fifo.sv
// Synchronous dibit FIFO, power-of-two depth, pointers wrap naturally.
// Latency: a pushed entry is visible on pop_dat the cycle after the push edge.
// Backpressure: a push while full or a pop while empty is ignored; the caller gates on full/empty.
module dibit_fifo
  import qpsk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  dibit_t                     push_dat,
  input  logic                       pop,
  output dibit_t                     pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  dibit_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/qpsk_bit_splitter.sv
// Pairs serial bits into (I,Q) dibits and holds each on Ichannel/Qchannel for SYMBOL_LEN clocks.
// Latency: a dibit appears 1 clock after its Q bit when idle, else at the next symbol boundary.
// Backpressure: bit_ready drops only when an I bit is pending and the dibit FIFO is full.
module qpsk_bit_splitter
  import qpsk_pkg::*;
#(
  parameter int         SYMBOL_LEN = 16,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] IDLE_DIBIT = QPSK_IDLE_DIBIT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            bit_in,
  input  logic                            bit_valid,
  output logic                            bit_ready,
  output logic                            Ichannel,
  output logic                            Qchannel,
  output logic                            sym_strobe,
  output logic                            sym_active,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int     CW     = $clog2(SYMBOL_LEN);
  localparam dibit_t IDLE_D = dibit_t'(IDLE_DIBIT);

  sym_state_t    state;
  sym_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  dibit_t        dibit_q;
  dibit_t        dibit_nxt;
  dibit_t        fifo_dat;
  logic          half;
  logic          pair_i;
  logic          bit_acc;
  logic          push_vld;
  logic          pop_vld;
  logic          fifo_full;
  logic          fifo_empty;
  logic          at_end;
  logic          strobe_nxt;
  logic          underrun_nxt;
  logic          active_nxt;

  // Registered state only: a pop on the same edge does not open a slot early.
  assign bit_ready = !rst && (!half || !fifo_full);
  assign bit_acc   = bit_valid && bit_ready;
  assign push_vld  = bit_acc && half;
  assign at_end    = (cnt == CW'(SYMBOL_LEN - 1));
  assign Ichannel  = dibit_q.i;
  assign Qchannel  = dibit_q.q;

  always_ff @(posedge clk) begin
    if (rst) begin
      half   <= 1'b0;
      pair_i <= 1'b0;
    end else if (bit_acc) begin
      half <= !half;
      if (!half) pair_i <= bit_in;
    end
  end

  dibit_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_vld),
    .push_dat(dibit_t'({pair_i, bit_in})),
    .pop     (pop_vld),
    .pop_dat (fifo_dat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dibit_q    <= IDLE_D;
      sym_strobe <= 1'b0;
      sym_active <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dibit_q    <= dibit_nxt;
      sym_strobe <= strobe_nxt;
      sym_active <= active_nxt;
      underrun   <= underrun_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = RUN;
      RUN:     if (at_end && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop_vld      = 1'b0;
    cnt_nxt      = cnt;
    dibit_nxt    = dibit_q;
    strobe_nxt   = 1'b0;
    underrun_nxt = 1'b0;
    active_nxt   = sym_active;
    case (state)
      IDLE: begin
        cnt_nxt    = '0;
        dibit_nxt  = IDLE_D;
        active_nxt = 1'b0;
        if (!fifo_empty) begin
          pop_vld    = 1'b1;
          dibit_nxt  = fifo_dat;
          strobe_nxt = 1'b1;
          active_nxt = 1'b1;
        end
      end
      RUN: begin
        if (at_end) begin
          cnt_nxt = '0;
          if (!fifo_empty) begin
            pop_vld    = 1'b1;
            dibit_nxt  = fifo_dat;
            strobe_nxt = 1'b1;
            active_nxt = 1'b1;
          end else begin
            dibit_nxt    = IDLE_D;
            underrun_nxt = 1'b1;
            active_nxt   = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        dibit_nxt = IDLE_D;
      end
    endcase
  end

endmodule

// File: tb/tb_qpsk_bit_splitter.sv
// Directed bench for qpsk_bit_splitter with SYMBOL_LEN=16, FIFO_DEPTH=4, idle dibit 11.
module tb_qpsk_bit_splitter;

  localparam int SYMBOL_LEN = 16;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_ready;
  logic       Ichannel;
  logic       Qchannel;
  logic       sym_strobe;
  logic       sym_active;
  logic       underrun;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ur_cyc   = 0;
  int strobe_cyc[$];
  logic [1:0] strobe_dib[$];

  qpsk_bit_splitter #(
    .SYMBOL_LEN(SYMBOL_LEN),
    .FIFO_DEPTH(FIFO_DEPTH),
    .IDLE_DIBIT(2'b11)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .Ichannel  (Ichannel),
    .Qchannel  (Qchannel),
    .sym_strobe(sym_strobe),
    .sym_active(sym_active),
    .underrun  (underrun),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sym_strobe) begin
      strobe_cyc.push_back(cyc);
      strobe_dib.push_back({Ichannel, Qchannel});
    end
    if (underrun) ur_cyc = cyc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    logic acc;
    bit_in    = b;
    bit_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      acc = bit_ready;
      step();
      if (acc) return;
    end
    n_checks++; n_fail++;
    $display("FAIL send_bit: bit_ready stayed 0 for 200 clocks, required 1");
  endtask

  task automatic wait_underrun(input string tag);
    for (int i = 0; i < 200; i++) begin
      step();
      if (underrun) return;
    end
    n_checks++; n_fail++;
    $display("FAIL %s_underrun_timeout: underrun not seen within 200 clocks, required a pulse", tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bit_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({Ichannel, Qchannel, bit_ready, fifo_level, sym_strobe, sym_active, underrun} !== {2'b11, 1'b0, 3'd0, 3'b000}) begin
        n_fail++;
        $display("FAIL reset_state: got IQ=%b rdy=%b lvl=%0d stb=%b act=%b ur=%b required IQ=11 rdy=0 lvl=0 stb=0 act=0 ur=0",
                 {Ichannel, Qchannel}, bit_ready, fifo_level, sym_strobe, sym_active, underrun);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bit_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b required 1", bit_ready);
    end
    step();
    n_checks++;
    if ({Ichannel, Qchannel, sym_strobe, sym_active} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_idle_after: got IQ/stb/act=%b required 1100", {Ichannel, Qchannel, sym_strobe, sym_active});
    end
  endtask

  task automatic test_single_dibit();
    int bad;
    send_bit(1'b1);
    send_bit(1'b0);
    bit_valid = 1'b0;
    n_checks++;
    if (fifo_level !== 3'd1 || {Ichannel, Qchannel} !== 2'b11) begin
      n_fail++; $display("FAIL single_queued: got lvl=%0d IQ=%b required lvl=1 IQ=11", fifo_level, {Ichannel, Qchannel});
    end
    step();
    n_checks++;
    if ({Ichannel, Qchannel, sym_strobe, sym_active, fifo_level} !== {2'b10, 2'b11, 3'd0}) begin
      n_fail++; $display("FAIL single_load: got IQ=%b stb=%b act=%b lvl=%0d required IQ=10 stb=1 act=1 lvl=0",
                         {Ichannel, Qchannel}, sym_strobe, sym_active, fifo_level);
    end
    bad = 0;
    for (int k = 1; k < SYMBOL_LEN; k++) begin
      step();
      if ({Ichannel, Qchannel, sym_strobe, sym_active, underrun} !== 5'b10010) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL single_hold: got %0d bad clocks in symbol body required 0", bad);
    end
    step();
    n_checks++;
    if ({Ichannel, Qchannel, underrun, sym_active} !== 4'b1110) begin
      n_fail++; $display("FAIL single_underrun: got IQ=%b ur=%b act=%b required IQ=11 ur=1 act=0",
                         {Ichannel, Qchannel}, underrun, sym_active);
    end
    step();
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++; $display("FAIL single_underrun_pulse: got %b one clock later required 0", underrun);
    end
  endtask

  task automatic test_half_pair();
    int bad;
    send_bit(1'b1);
    bit_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if ({Ichannel, Qchannel, sym_active, underrun, sym_strobe} !== 5'b11000) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL half_wait: got %0d bad clocks required 0", bad);
    end
    n_checks++;
    if (fifo_level !== 3'd0 || bit_ready !== 1'b1) begin
      n_fail++; $display("FAIL half_state: got lvl=%0d rdy=%b required lvl=0 rdy=1", fifo_level, bit_ready);
    end
    send_bit(1'b1);
    bit_valid = 1'b0;
    step();
    n_checks++;
    if ({Ichannel, Qchannel, sym_strobe, sym_active} !== 4'b1111) begin
      n_fail++; $display("FAIL half_complete: got IQ/stb/act=%b required 1111", {Ichannel, Qchannel, sym_strobe, sym_active});
    end
    wait_underrun("half");
    step();
  endtask

  task automatic test_stream();
    logic [9:0] bits;
    bits = 10'b1001110010;
    strobe_cyc.delete();
    strobe_dib.delete();
    for (int k = 9; k >= 0; k--) send_bit(bits[k]);
    n_checks++;
    if (fifo_level !== 3'd4 || bit_ready !== 1'b1) begin
      n_fail++; $display("FAIL stream_fill: got lvl=%0d rdy=%b required lvl=4 rdy=1", fifo_level, bit_ready);
    end
    send_bit(1'b1);
    n_checks++;
    if (bit_ready !== 1'b0 || fifo_level !== 3'd4) begin
      n_fail++; $display("FAIL stream_ready_drop: got rdy=%b lvl=%0d required rdy=0 lvl=4", bit_ready, fifo_level);
    end
  endtask

  task automatic test_push_pop();
    logic       acc;
    logic       found;
    logic [1:0] exp_dib [6];
    exp_dib = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11};
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    found = 1'b0;
    acc   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      acc = bit_ready;
      step();
      if (fifo_level == 3'd3) found = 1'b1;
    end
    n_checks++;
    if (!found || acc !== 1'b0 || sym_strobe !== 1'b1 || bit_ready !== 1'b1) begin
      n_fail++; $display("FAIL pushpop_boundary: got found=%b rdy_at_edge=%b stb=%b rdy_after=%b required 1 0 1 1",
                         found, acc, sym_strobe, bit_ready);
    end
    step();
    bit_valid = 1'b0;
    n_checks++;
    if (fifo_level !== 3'd4) begin
      n_fail++; $display("FAIL pushpop_refill: got lvl=%0d required 4", fifo_level);
    end
    wait_underrun("stream");
    step();
    n_checks++;
    if (strobe_dib.size() !== 6) begin
      n_fail++; $display("FAIL stream_count: got %0d symbols required 6", strobe_dib.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (strobe_dib[k] !== exp_dib[k]) begin
          n_fail++; $display("FAIL stream_dibit%0d: got %b required %b", k, strobe_dib[k], exp_dib[k]);
        end
        if (k > 0) begin
          n_checks++;
          if (strobe_cyc[k] - strobe_cyc[k-1] !== SYMBOL_LEN) begin
            n_fail++; $display("FAIL stream_spacing%0d: got %0d clocks required %0d", k, strobe_cyc[k] - strobe_cyc[k-1], SYMBOL_LEN);
          end
        end
      end
      n_checks++;
      if (ur_cyc - strobe_cyc[5] !== SYMBOL_LEN) begin
        n_fail++; $display("FAIL stream_tail: got underrun %0d clocks after last strobe required %0d", ur_cyc - strobe_cyc[5], SYMBOL_LEN);
      end
    end
  endtask

  task automatic test_reset_mid_symbol();
    logic [5:0] more;
    more = 6'b101101;
    send_bit(1'b0);
    send_bit(1'b1);
    step();
    n_checks++;
    if (sym_strobe !== 1'b1 || {Ichannel, Qchannel} !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_first: got stb=%b IQ=%b required stb=1 IQ=01", sym_strobe, {Ichannel, Qchannel});
    end
    for (int k = 5; k >= 0; k--) send_bit(more[k]);
    bit_valid = 1'b0;
    step();
    n_checks++;
    if (fifo_level !== 3'd3 || sym_active !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_queued: got lvl=%0d act=%b required lvl=3 act=1", fifo_level, sym_active);
    end
    rst = 1'b1;
    step();
    strobe_cyc.delete();
    strobe_dib.delete();
    n_checks++;
    if ({Ichannel, Qchannel, fifo_level, sym_active, sym_strobe, bit_ready} !== {2'b11, 3'd0, 3'b000}) begin
      n_fail++; $display("FAIL rstmid_clear: got IQ=%b lvl=%0d act=%b stb=%b rdy=%b required IQ=11 lvl=0 act=0 stb=0 rdy=0",
                         {Ichannel, Qchannel}, fifo_level, sym_active, sym_strobe, bit_ready);
    end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) step();
    n_checks++;
    if (strobe_cyc.size() !== 0 || {Ichannel, Qchannel} !== 2'b11) begin
      n_fail++; $display("FAIL rstmid_quiet: got %0d strobes IQ=%b required 0 strobes IQ=11", strobe_cyc.size(), {Ichannel, Qchannel});
    end
  endtask

  initial begin
    test_reset();
    test_single_dibit();
    test_half_pair();
    test_stream();
    test_push_pop();
    test_reset_mid_symbol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
